data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Bus-side responder for the single-cycle CPU's data-memory interface. Decodes the CPU's address/data/control bus and performs byte-addressed, little-endian sized loads and stores (byte, half, word, double, signed/unsigned). It sits outside the CPU at the opposite end of AddressBus/DataBus/ControlBus. Optionally, it exposes a memory-mapped console transmit FIFO drained by a valid/ready byte port.

## Interface
Parameters:
- MEM_BYTES, 4096: data memory size in bytes; power of two; equals `MEMORY_SIZE`.
- CONSOLE_ADDR, 64'hFFFF_FFFF_FFFF_FF00: console data register. A store here pushes a byte.
- FIFO_DEPTH, 16: console FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- AddressBus  in  64  byte address, which is the CPU ALU result.
- DataBusIn  in  64  store data, which is the CPU's rs2 value.
- DataBusOut  out  64  load data returned to the CPU.
- ControlBus  in  3  {MemWriteEn, MemReadEn, RegWriteEn}; bit 0 is ignored.
- SizeBus  in  3  access size and signedness in funct3 encoding: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu.
- tx_valid  out  1  console byte available (DMEM_MMIO_EN only).
- tx_data  out  8  console byte (DMEM_MMIO_EN only).
- tx_ready  in  1  consumer accepts the byte (DMEM_MMIO_EN only).

## Operation
- Memory is a byte array of size MEM_BYTES.
  - Effective index is AddressBus[log2(MEM_BYTES)-1:0].
  - Out-of-range addresses alias modulo MEM_BYTES.
  - Multi-byte accesses wrap byte-wise past the top of memory.
  - Misaligned accesses are legal.
- Store (MemWriteEn=1): writes the low 1/2/4/8 bytes of DataBusIn, little-endian, at the rising edge. SizeBus 100/101 on a store is treated as b/h.
- Load (MemReadEn=1): DataBusOut is driven combinationally.
  - Signed sizes sign-extend from the top loaded byte.
  - bu/hu zero-extend.
  - Reserved SizeBus codes 110/111 return 0.
- MemReadEn=0 or rst=1: DataBusOut=0.
- MemWriteEn and MemReadEn both set: the store is performed and the load returns pre-store data.
- Memory array contents are not cleared by rst. Initial contents are zero.
- Console (DMEM_MMIO_EN):
  - A store to CONSOLE_ADDR (any size) pushes DataBusIn[7:0] and does not write the array.
  - A load from CONSOLE_ADDR+8 returns status {58'b0, overflow, full, empty, count[2:0]} with count saturated at 7. The array is not read.
  - A push when full and no pop occurs that cycle is dropped and sets sticky `overflow`. Only rst clears `overflow`.
  - Push and pop in the same cycle while full: both occur and count is unchanged.

## Timing
- Load latency: 0 cycles (combinational). Store latency: visible to a load in the following cycle.
- FIFO push at rising edge: tx_valid rises the cycle after the push into an empty FIFO. There is no fall-through.
- Pop happens on a rising edge with tx_valid&tx_ready. tx_data is stable while tx_valid=1 and tx_ready=0.
- Read/write pointers are log2(FIFO_DEPTH) bits and wrap naturally; count is one bit wider.
- Reset values: tx_valid=0, tx_data=0, count=0, pointers=0, overflow=0, DataBusOut=0.
- rst mid-transfer empties the FIFO. Queued bytes are lost and tx_valid is 0 the next cycle.

## Configuration
- DMEM_MMIO_EN defined: console decode, FIFO, status register and tx_* ports are present.
- DMEM_MMIO_EN undefined:
  - tx_* ports are absent.
  - CONSOLE_ADDR and CONSOLE_ADDR+8 are ordinary aliased memory addresses.
  - The block is pure sized memory.

## Structure
- defs.h holds:
  - SizeBus encodings (SIZE_B … SIZE_HU).
  - `BIT_WIDTH`, `MEMORY_SIZE`.
  - The ControlBus bit positions (CB_MEMWRITE=2, CB_MEMREAD=1, CB_REGWRITE=0), shared with the CPU.
- Sub-module `console_tx_fifo`: synchronous FIFO with push/pop, full, empty, count and overflow. It is instantiated only under DMEM_MMIO_EN.

## Test plan
- sd 64'h8877_6655_4433_2211 to addr 16, then ld 16 → 64'h8877_6655_4433_2211. lb 23 → 64'hFFFF_FFFF_FFFF_FF88. lbu 23 → 64'h88. lhu 22 → 64'h8877.
- sw 64'hDEAD_BEEF_1234_5678 to addr MEM_BYTES-2 → bytes 78,56 land at top, 34,12 at addr 0,1. lw MEM_BYTES-2 → 64'h0000_0000_1234_5678.
- MemReadEn=0 with any address → DataBusOut=0. Reserved SizeBus 110 load → 0.
- MMIO: store 0x41, 0x42 to CONSOLE_ADDR with tx_ready=0 → tx_valid=1 the cycle after the first push. Status reads count=2, empty=0. Then tx_ready=1 → 0x41 then 0x42 are popped, then tx_valid=0.
- Fill FIFO_DEPTH bytes with tx_ready=0, then push one more → it is dropped, status overflow=1, full=1. A push with a simultaneous pop while full → count stays FIFO_DEPTH.
- Assert rst with 3 bytes queued → next cycle tx_valid=0, status=empty, overflow=0. A prior memory store is still readable after reset.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared bus definitions for the data-memory responder and the CPU:
// size encodings, bus widths and ControlBus bit positions.
package data_mem_responder_pkg;

   localparam int BIT_WIDTH   = 64;
   localparam int MEMORY_SIZE = 4096;

   localparam int CB_MEMWRITE = 2;
   localparam int CB_MEMREAD  = 1;
   localparam int CB_REGWRITE = 0;

   typedef enum logic [2:0] {
      SIZE_B  = 3'b000,
      SIZE_H  = 3'b001,
      SIZE_W  = 3'b010,
      SIZE_D  = 3'b011,
      SIZE_BU = 3'b100,
      SIZE_HU = 3'b101
   } size_e;

   // Reserved codes store nothing.
   function automatic logic [3:0] size_bytes(input logic [2:0] sz);
      logic [3:0] n;
      n = 4'd0;
      case (sz)
         SIZE_B, SIZE_BU: n = 4'd1;
         SIZE_H, SIZE_HU: n = 4'd2;
         SIZE_W:          n = 4'd4;
         SIZE_D:          n = 4'd8;
         default:         n = 4'd0;
      endcase
      return n;
   endfunction

   function automatic logic [63:0] load_extend(
      input logic [63:0] raw,
      input logic [2:0]  sz
   );
      logic [63:0] r;
      r = '0;
      case (sz)
         SIZE_B:  r = {{56{raw[7]}}, raw[7:0]};
         SIZE_H:  r = {{48{raw[15]}}, raw[15:0]};
         SIZE_W:  r = {{32{raw[31]}}, raw[31:0]};
         SIZE_D:  r = raw;
         SIZE_BU: r = {56'b0, raw[7:0]};
         SIZE_HU: r = {48'b0, raw[15:0]};
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/data_mem_responder_console_tx_fifo.sv
// Console transmit FIFO: push from the bus side, drained through a
// valid/ready byte port. Drops pushes when full and flags overflow.
module console_tx_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [7:0]                 push_data,
   input  logic                       pop,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       out_valid,
   output logic [7:0]                 out_data
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [7:0]    slots [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          pop_ok;
   logic          push_ok;

   assign full     = count == CW'(DEPTH);
   assign empty    = count == '0;
   assign pop_ok   = pop & ~empty;
   // A full FIFO still accepts a push when the head leaves this cycle.
   assign push_ok  = push & (~full | pop_ok);

   assign out_valid = ~empty;
   assign out_data  = empty ? 8'h00 : slots[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push_ok) - CW'(pop_ok);
         if (push & ~push_ok)
            overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         slots[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/data_mem_responder.sv
// Byte-addressed little-endian data memory on the CPU bus. Defining
// DMEM_MMIO_EN adds a memory-mapped console transmit FIFO.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int          MEM_BYTES    = MEMORY_SIZE,
   parameter logic [63:0] CONSOLE_ADDR = 64'hFFFF_FFFF_FFFF_FF00,
   parameter int          FIFO_DEPTH   = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] AddressBus,
   input  logic [63:0] DataBusIn,
   output logic [63:0] DataBusOut,
   input  logic [2:0]  ControlBus,
   input  logic [2:0]  SizeBus
`ifdef DMEM_MMIO_EN
  ,output logic        tx_valid
  ,output logic [7:0]  tx_data
  ,input  logic        tx_ready
`endif
);

   localparam int AW = $clog2(MEM_BYTES);

   logic [7:0]    mem [MEM_BYTES];
   logic [AW-1:0] idx;
   logic          wr_en;
   logic          rd_en;
   logic          console_hit;
   logic          status_hit;
   logic          mem_we;
   logic [63:0]   raw;
   logic [63:0]   status;
   logic [3:0]    nbytes;

   assign idx    = AddressBus[AW-1:0];
   assign wr_en  = ControlBus[CB_MEMWRITE];
   assign rd_en  = ControlBus[CB_MEMREAD];
   assign nbytes = size_bytes(SizeBus);
   assign mem_we = wr_en & ~console_hit;

   logic unused_ok;
   assign unused_ok = ^{ControlBus[CB_REGWRITE], AddressBus[63:AW],
                        CONSOLE_ADDR, FIFO_DEPTH[0]};

`ifdef DMEM_MMIO_EN
   localparam int PW = $clog2(FIFO_DEPTH);

   logic          fifo_full;
   logic          fifo_empty;
   logic          fifo_ovf;
   logic [PW:0]   fifo_count;
   logic [31:0]   cnt32;
   logic [2:0]    cnt_sat;

   assign console_hit = AddressBus == CONSOLE_ADDR;
   assign status_hit  = AddressBus == CONSOLE_ADDR + 64'd8;
   assign cnt32       = 32'(fifo_count);
   assign cnt_sat     = (cnt32 > 32'd7) ? 3'd7 : cnt32[2:0];
   assign status      = {58'b0, fifo_ovf, fifo_full, fifo_empty, cnt_sat};

   console_tx_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (wr_en & console_hit),
      .push_data (DataBusIn[7:0]),
      .pop       (tx_ready),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count),
      .overflow  (fifo_ovf),
      .out_valid (tx_valid),
      .out_data  (tx_data)
   );
`else
   assign console_hit = 1'b0;
   assign status_hit  = 1'b0;
   assign status      = '0;
`endif

   // Eight bytes from idx upward, wrapping past the top of memory.
   always_comb begin
      raw = '0;
      for (int k = 0; k < 8; k++)
         raw[8*k +: 8] = mem[idx + AW'(k)];
   end

   always_comb begin
      DataBusOut = '0;
      if (!rst && rd_en) begin
         if (status_hit)
            DataBusOut = status;
         else
            DataBusOut = load_extend(raw, SizeBus);
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int k = 0; k < 8; k++)
            if (4'(k) < nbytes)
               mem[idx + AW'(k)] <= DataBusIn[8*k +: 8];
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder; console checks run when
// DMEM_MMIO_EN is defined.
module tb_data_mem_responder;
   import data_mem_responder_pkg::*;

   localparam int          MB  = 4096;
   localparam logic [63:0] CON = 64'hFFFF_FFFF_FFFF_FF00;
   localparam logic [2:0]  WR  = 3'b100;
   localparam logic [2:0]  RD  = 3'b010;
   localparam logic [2:0]  RW  = 3'b110;
   localparam logic [2:0]  IDLE = 3'b000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] AddressBus = '0;
   logic [63:0] DataBusIn = '0;
   logic [63:0] DataBusOut;
   logic [2:0]  ControlBus = '0;
   logic [2:0]  SizeBus = '0;
`ifdef DMEM_MMIO_EN
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready = 1'b0;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   data_mem_responder #(
      .MEM_BYTES    (MB),
      .CONSOLE_ADDR (CON),
      .FIFO_DEPTH   (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .AddressBus (AddressBus),
      .DataBusIn  (DataBusIn),
      .DataBusOut (DataBusOut),
      .ControlBus (ControlBus),
      .SizeBus    (SizeBus)
`ifdef DMEM_MMIO_EN
     ,.tx_valid   (tx_valid)
     ,.tx_data    (tx_data)
     ,.tx_ready   (tx_ready)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive one bus cycle just after the falling edge, settle for 1ns.
   task automatic drive(input logic [63:0] a, input logic [63:0] d,
                        input logic [2:0] s, input logic [2:0] c);
      @(negedge clk);
      AddressBus = a;
      DataBusIn  = d;
      SizeBus    = s;
      ControlBus = c;
      #1;
   endtask

   initial begin
      drive(64'd16, '0, SIZE_D, RD);
      chk("rst_dout", DataBusOut, 64'h0);
`ifdef DMEM_MMIO_EN
      chk("rst_txv", 64'(tx_valid), 64'h0);
      chk("rst_txd", 64'(tx_data), 64'h0);
`endif
      drive('0, '0, SIZE_B, IDLE);
      rst = 1'b0;

      drive(64'd16, 64'h8877_6655_4433_2211, SIZE_D, WR);
      drive(64'd16, '0, SIZE_D, RD);
      chk("ld16", DataBusOut, 64'h8877_6655_4433_2211);
      drive(64'd23, '0, SIZE_B, RD);
      chk("lb23", DataBusOut, 64'hFFFF_FFFF_FFFF_FF88);
      drive(64'd23, '0, SIZE_BU, RD);
      chk("lbu23", DataBusOut, 64'h88);
      drive(64'd22, '0, SIZE_HU, RD);
      chk("lhu22", DataBusOut, 64'h8877);
      drive(64'd22, '0, SIZE_H, RD);
      chk("lh22", DataBusOut, 64'hFFFF_FFFF_FFFF_8877);
      drive(64'd20, '0, SIZE_W, RD);
      chk("lw20", DataBusOut, 64'hFFFF_FFFF_8877_6655);
      drive(64'd16 + 64'(MB), '0, SIZE_D, RD);
      chk("alias", DataBusOut, 64'h8877_6655_4433_2211);

      drive(64'(MB - 2), 64'hDEAD_BEEF_1234_5678, SIZE_W, WR);
      drive(64'(MB - 2), '0, SIZE_W, RD);
      chk("lw_wrap", DataBusOut, 64'h1234_5678);
      drive(64'(MB - 1), '0, SIZE_BU, RD);
      chk("lbu_top", DataBusOut, 64'h56);
      drive(64'd0, '0, SIZE_BU, RD);
      chk("lbu_0", DataBusOut, 64'h34);
      drive(64'd1, '0, SIZE_BU, RD);
      chk("lbu_1", DataBusOut, 64'h12);

      drive(64'd16, '0, SIZE_D, IDLE);
      chk("rd_off", DataBusOut, 64'h0);
      drive(64'd16, '0, 3'b110, RD);
      chk("rsv110", DataBusOut, 64'h0);
      drive(64'd16, '0, 3'b111, RD);
      chk("rsv111", DataBusOut, 64'h0);

      drive(64'd16, 64'hAA, SIZE_B, RW);
      chk("rw_old", DataBusOut, 64'h11);
      drive(64'd16, '0, SIZE_BU, RD);
      chk("rw_new", DataBusOut, 64'hAA);

`ifdef DMEM_MMIO_EN
      drive(CON, 64'h41, SIZE_B, WR);
      chk("txv_pre", 64'(tx_valid), 64'h0);
      drive(CON, 64'h42, SIZE_B, WR);
      chk("txv_1", 64'(tx_valid), 64'h1);
      chk("txd_41", 64'(tx_data), 64'h41);
      drive(CON + 64'd8, '0, SIZE_D, RD);
      chk("stat_2", DataBusOut, 64'h02);
      drive(CON, '0, SIZE_BU, RD);
      chk("con_nomem", DataBusOut, 64'h0);
      drive('0, '0, SIZE_B, IDLE);
      tx_ready = 1'b1;
      chk("pop_41", 64'(tx_data), 64'h41);
      drive('0, '0, SIZE_B, IDLE);
      chk("pop_42", 64'(tx_data), 64'h42);
      drive('0, '0, SIZE_B, IDLE);
      tx_ready = 1'b0;
      chk("drained", 64'(tx_valid), 64'h0);

      for (int i = 0; i < 16; i++)
         drive(CON, 64'(8'h60 + i), SIZE_B, WR);
      drive(CON + 64'd8, '0, SIZE_D, RD);
      chk("stat_full", DataBusOut, 64'h17);
      drive(CON, 64'h70, SIZE_B, WR);
      drive(CON + 64'd8, '0, SIZE_D, RD);
      chk("stat_ovf", DataBusOut, 64'h37);
      chk("head_60", 64'(tx_data), 64'h60);
      drive(CON, 64'h99, SIZE_B, WR);
      tx_ready = 1'b1;
      drive(CON + 64'd8, '0, SIZE_D, RD);
      tx_ready = 1'b0;
      chk("stat_pp", DataBusOut, 64'h37);
      chk("head_61", 64'(tx_data), 64'h61);
      tx_ready = 1'b1;
      for (int i = 0; i < 15; i++)
         drive('0, '0, SIZE_B, IDLE);
      tx_ready = 1'b0;
      drive(CON + 64'd8, '0, SIZE_D, RD);
      chk("tail_99", 64'(tx_data), 64'h99);
      chk("stat_1", DataBusOut, 64'h21);

      drive('0, '0, SIZE_B, IDLE);
      rst = 1'b1;
      drive('0, '0, SIZE_B, IDLE);
      rst = 1'b0;
      for (int i = 0; i < 3; i++)
         drive(CON, 64'(8'hC0 + i), SIZE_B, WR);
      drive(CON + 64'd8, '0, SIZE_D, RD);
      chk("stat_3", DataBusOut, 64'h03);
      rst = 1'b1;
      chk("rst_dout2", DataBusOut, 64'h0);
      drive('0, '0, SIZE_B, IDLE);
      rst = 1'b0;
      chk("rst_txv2", 64'(tx_valid), 64'h0);
      drive(CON + 64'd8, '0, SIZE_D, RD);
      chk("stat_rst", DataBusOut, 64'h08);
`endif

      drive(64'd16, '0, SIZE_D, RD);
      chk("mem_kept", DataBusOut, 64'h8877_6655_4433_22AA);
      drive('0, '0, SIZE_B, IDLE);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
